// File: rtl/shift_exec_stage_pkg.sv
// Shared types and constants for the shift execute stage.
package shift_exec_stage_pkg;

    localparam int SHIFT_XLEN = 32;
    localparam int SHIFT_TAGW = 5;
    localparam int SHAMT_W    = 5;

    typedef enum logic [1:0] {
        SHIFT_OP_SLL  = 2'b00,
        SHIFT_OP_SRL  = 2'b01,
        SHIFT_OP_SRA  = 2'b10,
        SHIFT_OP_RSVD = 2'b11
    } shift_op_t;

    // Operands captured in S1; the shift amount is already resolved
    // from register or immediate.
    typedef struct packed {
        logic [SHIFT_XLEN-1:0] a;
        logic [SHAMT_W-1:0]    shamt;
        shift_op_t             op;
        logic [SHIFT_TAGW-1:0] tag;
    } s1_payload_t;

    // True when the op needs a right shift from the core shifter.
    function automatic logic is_right_shift(input shift_op_t op);
        return (op == SHIFT_OP_SRL) || (op == SHIFT_OP_SRA);
    endfunction

endpackage

// File: rtl/shift_exec_stage_shifter.sv
// Shared 32-bit combinational logarithmic shifter.
// op = 0 shifts left (SLL), op = 1 shifts right logically (SRL).
module shift_exec_stage_shifter
    import shift_exec_stage_pkg::*;
(
    input  logic [SHIFT_XLEN-1:0] a,
    input  logic [SHAMT_W-1:0]    shamt,
    input  logic                  op,
    output logic [SHIFT_XLEN-1:0] result
);

    // stage_val[k] holds the operand after the first k shift stages.
    logic [SHIFT_XLEN-1:0] stage_val [0:SHAMT_W];

    assign stage_val[0] = a;

    // Each stage shifts by a power of two when the matching shamt bit is set.
    generate
        for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            logic [SHIFT_XLEN-1:0] shifted;
            assign shifted = op ? (stage_val[gi] >> SH) : (stage_val[gi] << SH);
            assign stage_val[gi+1] = shamt[gi] ? shifted : stage_val[gi];
        end
    endgenerate

    assign result = stage_val[SHAMT_W];

endmodule

// File: rtl/shift_exec_stage.sv
// Two-register execute stage for shift micro-ops: operand capture in S1,
// shift plus SRA sign fill between S1 and S2, tagged result held in S2
// until writeback accepts it.
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int XLEN = SHIFT_XLEN,
    parameter int TAGW = SHIFT_TAGW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_imm,
    input  logic            in_use_imm,
    input  logic [1:0]      in_op,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_tag,
    output logic            out_illegal
);

    logic        s1_valid_reg;
    logic        s2_valid_reg;
    s1_payload_t s1_reg;
    s1_payload_t s1_next;

    logic            s1_adv;
    logic            s2_adv;
    logic            core_right;
    logic [XLEN-1:0] core_result;
    logic [XLEN-1:0] sign_mask;
    logic [XLEN-1:0] result_next;
    logic            illegal_next;

    logic [XLEN-1:0] result_reg;
    logic [TAGW-1:0] tag_reg;
    logic            illegal_reg;

    // An empty stage always accepts; a full stage accepts only if it can drain.
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    // Resolve the shift amount before capture so S1 holds only what the shifter needs.
    always_comb begin
        s1_next       = '0;
        s1_next.a     = in_a;
        s1_next.shamt = in_use_imm ? in_imm : in_rs2[4:0];
        s1_next.op    = shift_op_t'(in_op);
        s1_next.tag   = in_tag;
    end

    // Pipeline occupancy; flush wins over any advance or acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
            end
            if (s1_adv) begin
                s1_valid_reg <= in_valid;
            end
        end
    end

    // S1 operand capture; contents are meaningless while s1_valid_reg is low.
    always_ff @(posedge clk) begin
        if (in_valid && s1_adv) begin
            s1_reg <= s1_next;
        end
    end

    assign core_right = is_right_shift(s1_reg.op);

    shift_exec_stage_shifter u_shifter (
        .a      (s1_reg.a),
        .shamt  (s1_reg.shamt),
        .op     (core_right),
        .result (core_result)
    );

    // Upper bits vacated by a right shift, filled with ones for negative SRA.
    assign sign_mask = s1_reg.a[XLEN-1] ? ~({XLEN{1'b1}} >> s1_reg.shamt) : '0;

    // Final result select, including SRA fill and the reserved encoding.
    always_comb begin
        result_next  = '0;
        illegal_next = 1'b0;
        unique case (s1_reg.op)
            SHIFT_OP_SLL,
            SHIFT_OP_SRL:  result_next = core_result;
            SHIFT_OP_SRA:  result_next = core_result | sign_mask;
            SHIFT_OP_RSVD: illegal_next = 1'b1;
            default:       illegal_next = 1'b1;
        endcase
    end

    // S2 output register; reset to zero so idle outputs are clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg  <= '0;
            tag_reg     <= '0;
            illegal_reg <= 1'b0;
        end else if (s1_valid_reg && s2_adv) begin
            result_reg  <= result_next;
            tag_reg     <= s1_reg.tag;
            illegal_reg <= illegal_next;
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_result  = result_reg;
    assign out_tag     = tag_reg;
    assign out_illegal = illegal_reg;

endmodule
